mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single pipelined SRAM memory port (the mem_* bus driven into sram_ctrl or blockram) between the yari CPU (master 0) and a second bus master (master 1, e.g. VGA framebuffer fetch or DMA).
- Arbitration is round-robin, or fixed priority to master 0 with a starvation guard.
- The arbiter tags each downstream request with the issuing master's ID and routes returning read data by mem_readdataid.

Parameters:
- FIXED_PRIO, 0: 0 selects round-robin; 1 gives master 0 priority.
- MAX_WAIT, 15: in fixed-priority mode, the number of cycles master 1 may be denied before it is forcibly granted. Range 1..255.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous reset, active high
- mN_read  in  1  read request (N = 0, 1; same for every mN_ line below)
- mN_write  in  1  write request
- mN_address  in  30  word address
- mN_writedata  in  32  write data
- mN_writedatamask  in  4  byte enables
- mN_waitrequest  out  1  stall; the master holds its command stable while this is 1
- mN_readdata  out  32  returned read data
- mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata
- mem_waitrequest  in  1  downstream stall
- mem_id  out  2  request tag
- mem_address  out  30  downstream word address
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_writedata  out  32  downstream write data
- mem_writedatamask  out  4  downstream byte enables
- mem_readdata  in  32  downstream read data
- mem_readdataid  in  2  tag of mem_readdata; 0 means no data this cycle
- grant  out  2  current owner, one-hot or 0; for debug LEDs

Behaviour:
- A master is "requesting" when mN_read or mN_write is 1. Read and write asserted together by one master is illegal and goes unchecked.
- State machine states: IDLE, G0, G1. The state is registered and is exactly the grant output: IDLE=00, G0=01, G1=10.
- Reset (asynchronous) forces:
  - state to IDLE and the round-robin pointer to master 0;
  - the wait counter to 0;
  - mem_read, mem_write, mem_id, mN_readdatavalid to 0;
  - mN_waitrequest to 1.
- In IDLE:
  - no downstream command is issued;
  - both mN_waitrequest are 1;
  - the arbiter picks a winner among the requesters and enters G0 or G1 on the next edge, so there is 1 cycle of arbitration latency.
- In GN:
  - the mem_* command fields are muxed combinationally from master N;
  - mem_id = 2'b01 for master 0 and 2'b10 for master 1; 2'b11 is unused;
  - mN_waitrequest = mem_waitrequest;
  - the other master sees waitrequest = 1.
- Acceptance occurs when a command is on mem_read/mem_write and mem_waitrequest=0.
- The grant never changes while a command is presented but not yet accepted.
- On the acceptance cycle the next state is chosen by the arbitration rule from the requests sampled that cycle:
  - the current master may be regranted, giving back-to-back transfers with no bubble;
  - if no one is requesting, the next state is IDLE.
- If master N drops its request while in GN without acceptance, the state goes to IDLE. This is a protocol violation and is flagged by an assertion in simulation.
- Round-robin rule:
  - the pointer toggles to the other master on each acceptance;
  - the other master wins whenever both are requesting;
  - a lone requester always wins.
- Fixed-priority rule:
  - master 0 wins ties;
  - the wait counter increments each cycle master 1 requests without being granted, saturating at 255;
  - the counter clears on master 1 acceptance;
  - when the counter reaches MAX_WAIT, master 1 wins the next decision regardless of master 0.
- Read return:
  - mem_readdata and mem_readdataid are registered one cycle;
  - tag 01 drives m0_readdata/m0_readdatavalid and tag 10 drives master 1;
  - the return path is independent of the grant, so data returns while the other master owns the bus;
  - readdata ordering per master follows the downstream ordering; the arbiter has no reorder buffer;
  - a return with tag 00 or 11 is dropped, with no strobe.
- Reset mid-transfer: outstanding reads are abandoned, and any returns arriving after reset deassertion are still routed by tag.

Test Plan:
- Single master: after reset, m0_read with address 0x100 and mem_waitrequest=0 → grant=01 one cycle later; mem_read=1, mem_id=01; tag-01 data 0xDEADBEEF returns as m0_readdata with one strobe, 1 cycle after it appears on the mem bus.
- Round-robin: both masters issue continuous reads, FIXED_PRIO=0 → accepted mem_id sequence alternates 01,10,01,10 with no idle cycles between acceptances.
- Stall hold: grant to m1 with a write; mem_waitrequest held high 5 cycles while m0 is also requesting → grant stays 10, mem_* stable all 5 cycles, m0_waitrequest=1 throughout; m1's write accepted on cycle 6.
- Starvation guard: FIXED_PRIO=1, MAX_WAIT=4, m0 continuous reads, m1 read → m1 accepted no later than its 6th request cycle; counter back to 0 afterwards.
- Interleaved returns: m0 and m1 reads outstanding; tags 10,01,10 return on consecutive cycles → each master receives only its own data and strobes, with correct values.
- Async reset: assert rst mid-stall in G1 → grant=00, mem_read=mem_write=0 and both waitrequests=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master arbiter for the pipelined SRAM memory port
// Purpose: shares one mem_* command port between master 0 (CPU) and master 1
//          (framebuffer fetch / DMA), tags each command with the issuing
//          master's ID and routes registered read returns by that tag.
// Ports:   clock, rst            clock and asynchronous active-high reset
//          mN_read/write/address/writedata/writedatamask   master N command
//          mN_waitrequest        stall towards master N
//          mN_readdata/readdatavalid                       master N read return
//          mem_*                 downstream command, stall and read return
//          grant                 current owner (one-hot or 0), equals state
module mem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 15
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [29:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_writedatamask,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [29:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_writedatamask,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    input  logic        mem_waitrequest,
    output logic [1:0]  mem_id,
    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_readdataid,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;
    state_t      win_state;
    logic        rr_ptr;       // master that wins a tie in round-robin mode
    logic        rr_ptr_next;
    logic [7:0]  wait_cnt;     // cycles master 1 has been kept waiting
    logic [31:0] rd_data_q;
    logic [1:0]  rd_id_q;
    logic [1:0]  stalled_q;
    logic        m0_req;
    logic        m1_req;
    logic        accept;
    logic        starved;
    logic        tie1;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;
    assign grant  = state;

    // Command mux: the owner drives mem_*, everyone else is stalled.
    always_comb begin
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        mem_id            = 2'b00;
        mem_address       = m0_address;
        mem_writedata     = m0_writedata;
        mem_writedatamask = m0_writedatamask;
        m0_waitrequest    = 1'b1;
        m1_waitrequest    = 1'b1;
        case (state)
            G0: begin
                mem_read       = m0_read;
                mem_write      = m0_write;
                mem_id         = 2'b01;
                m0_waitrequest = mem_waitrequest;
            end
            G1: begin
                mem_read          = m1_read;
                mem_write         = m1_write;
                mem_id            = 2'b10;
                mem_address       = m1_address;
                mem_writedata     = m1_writedata;
                mem_writedatamask = m1_writedatamask;
                m1_waitrequest    = mem_waitrequest;
            end
            default: ;
        endcase
    end

    assign accept = (mem_read | mem_write) & ~mem_waitrequest;

    // While master 1 owns the bus it is not being starved; on its acceptance
    // the counter is cleared, so the guard must not regrant it again.
    assign starved = (int'(wait_cnt) >= MAX_WAIT) && (state != G1);

    // Winner among the requests sampled this cycle. On an acceptance the
    // round-robin pointer has effectively already moved to the other master.
    always_comb begin
        tie1 = rr_ptr;
        if (accept) begin
            tie1 = (state == G0);
        end
        if (FIXED_PRIO != 0) begin
            tie1 = starved;
        end
        if (!m0_req && !m1_req) begin
            win_state = IDLE;
        end else if (m1_req && (!m0_req || tie1)) begin
            win_state = G1;
        end else begin
            win_state = G0;
        end
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: state_next = win_state;
            G0: begin
                if (accept) begin
                    rr_ptr_next = 1'b1;
                    state_next  = win_state;
                end else if (!m0_req) begin
                    state_next = IDLE;
                end
            end
            G1: begin
                if (accept) begin
                    rr_ptr_next = 1'b0;
                    state_next  = win_state;
                end else if (!m1_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            wait_cnt  <= 8'd0;
            rd_id_q   <= 2'b00;
            stalled_q <= 2'b00;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            rd_id_q   <= mem_readdataid;
            stalled_q <= {m1_req & m1_waitrequest, m0_req & m0_waitrequest};
            if (state == G1 && accept) begin
                wait_cnt <= 8'd0;
            end else if (m1_req && state != G1 && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Return data needs no reset: it is only observed under a valid strobe.
    always_ff @(posedge clock) begin
        rd_data_q <= mem_readdata;
    end

    // Returns are routed purely by tag, independent of the current grant.
    assign m0_readdata      = rd_data_q;
    assign m1_readdata      = rd_data_q;
    assign m0_readdatavalid = (rd_id_q == 2'b01);
    assign m1_readdatavalid = (rd_id_q == 2'b10);

    // A master that was stalled must keep its command up until accepted.
    always @(posedge clock) begin
        if (!rst) begin
            assert (!(stalled_q[0] && !m0_req));
            assert (!(stalled_q[1] && !m1_req));
        end
    end

endmodule
